// File: rtl/valid_stream_receiver_if.sv
// Valid-only upstream in, valid/ready downstream out.
// Also carries the occupancy and overflow status.
interface valid_stream_receiver_if #(
  parameter int width = 8,
  parameter int depth = 4
);
  localparam int CW = $clog2(depth + 1);

  logic             in_vld;
  logic [width-1:0] in_data;
  logic             out_vld;
  logic [width-1:0] out_data;
  logic             out_rdy;
  logic [CW-1:0]    count;
  logic             overflow;

  modport slave (
    input  in_vld,
    input  in_data,
    input  out_rdy,
    output out_vld,
    output out_data,
    output count,
    output overflow
  );

  modport master (
    output in_vld,
    output in_data,
    output out_rdy,
    input  out_vld,
    input  out_data,
    input  count,
    input  overflow
  );
endinterface

// File: rtl/valid_stream_receiver.sv
// Buffers a valid-only stream in a small FIFO and
// re-presents it over valid/ready; flags dropped transfers.
module valid_stream_receiver #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input logic clk,
  input logic rst,
  valid_stream_receiver_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_out_vld;
  logic w_pop;
  logic w_push;

  assign w_out_vld = (r_count != '0);
  assign w_pop     = w_out_vld & bus.out_rdy;
  // A pop frees a slot in the same cycle, so full + pop still accepts.
  assign w_push    = bus.in_vld & ((r_count < FULL) | w_pop);

  assign bus.out_vld  = w_out_vld;
  assign bus.out_data = r_mem[r_rp];
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;

  // Storage write; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= bus.in_data;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
      if (bus.in_vld && !w_push)
        r_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_valid_stream_receiver.sv
// Random and directed bench for valid_stream_receiver
// against a queue-based reference model.
module tb_valid_stream_receiver;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  valid_stream_receiver_if #(.width(W), .depth(D)) bus ();

  valid_stream_receiver #(.width(W), .depth(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue with capacity D.
  logic [W-1:0] mq [$];
  logic         m_ovf = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      bit pop;
      pop = (mq.size() != 0) && (bus.out_rdy === 1'b1);
      if (pop) void'(mq.pop_front());
      if (bus.in_vld === 1'b1) begin
        if (mq.size() < D) mq.push_back(bus.in_data);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_vld", 32'(bus.out_vld), 32'(mq.size() != 0));
    chk("m_cnt", 32'(bus.count), 32'(mq.size()));
    chk("m_ovf", 32'(bus.overflow), 32'(m_ovf));
    if (mq.size() != 0)
      chk("m_data", 32'(bus.out_data), 32'(mq[0]));
  end

  // Apply inputs for the next edge, return just after it.
  task automatic drive(input logic v,
                       input logic [W-1:0] d,
                       input logic r);
    bus.in_vld  = v;
    bus.in_data = d;
    bus.out_rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_cnt", 32'(bus.count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b1;

    // Single transfer
    drive(1'b1, 8'hA5, 1'b1);
    chk("one_vld", 32'(bus.out_vld), 32'd1);
    chk("one_data", 32'(bus.out_data), 32'hA5);
    drive(1'b0, 8'h00, 1'b1);
    chk("one_gone", 32'(bus.out_vld), 32'd0);

    // Continuous stream, one cycle delay
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      chk("strm_data", 32'(bus.out_data), 32'(i));
      chk("strm_cnt", 32'(bus.count), 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("strm_ovf", 32'(bus.overflow), 32'd0);

    // Fill and overflow
    for (int i = 0; i < 5; i++)
      drive(1'b1, 8'(8'h10 + i), 1'b0);
    chk("fill_cnt", 32'(bus.count), 32'd4);
    chk("fill_ovf", 32'(bus.overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("drn_data", 32'(bus.out_data), 32'(8'h10 + k));
      drive(1'b0, 8'h00, 1'b1);
    end
    chk("drn_vld", 32'(bus.out_vld), 32'd0);
    chk("drn_ovf", 32'(bus.overflow), 32'd1);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 8'(i), 1'b0);
    drive(1'b1, 8'd5, 1'b1);
    chk("fp_cnt", 32'(bus.count), 32'd4);
    chk("fp_ovf", 32'(bus.overflow), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      chk("fp_data", 32'(bus.out_data), 32'(k));
      drive(1'b0, 8'h00, 1'b1);
    end
    chk("fp_vld", 32'(bus.out_vld), 32'd0);

    // Random traffic with stalls
    do_reset();
    for (int i = 0; i < 1000; i++)
      drive(1'(($urandom % 2) == 0),
            8'($urandom),
            1'($urandom % 2));

    // Async reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'(8'h30 + i), 1'b0);
    chk("ar_pre", 32'(bus.count), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_vld", 32'(bus.out_vld), 32'd0);
    chk("ar_cnt", 32'(bus.count), 32'd0);
    rst = 1'b1;
    drive(1'b1, 8'h77, 1'b1);
    chk("ar_data", 32'(bus.out_data), 32'h77);
    chk("ar_vld2", 32'(bus.out_vld), 32'd1);
    drive(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
